// File: rtl/r5p_bus_arb.sv
// Round-robin N-to-1 bus arbiter in front of the system bus decoder.
// Grants are frozen while a stalled request waits; read data is steered back to the last transfer's owner.
//
// state | meaning
// ARB   | grant chosen each cycle, searching upward from ptr
// HOLD  | previous request stalled by m_rdy=0, grant frozen to hgnt
module r5p_bus_arb #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = DW/8,
    parameter int unsigned BN = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [BN-1:0]    s_vld,
    input  logic [BN-1:0]    s_wen,
    input  logic [BN*BW-1:0] s_ben,
    input  logic [BN*AW-1:0] s_adr,
    input  logic [BN*DW-1:0] s_wdt,
    output logic [BN*DW-1:0] s_rdt,
    output logic [BN-1:0]    s_rdy,
    output logic             m_vld,
    output logic             m_wen,
    output logic [BW-1:0]    m_ben,
    output logic [AW-1:0]    m_adr,
    output logic [DW-1:0]    m_wdt,
    input  logic [DW-1:0]    m_rdt,
    input  logic             m_rdy
);

    localparam int unsigned IW = (BN > 1) ? $clog2(BN) : 1;

    typedef enum logic [0:0] {ARB = 1'b0, HOLD = 1'b1} st_t;

    st_t           st;
    logic [IW-1:0] ptr;
    logic [BN-1:0] hgnt;
    logic [BN-1:0] own;
    logic [BN-1:0] gnt;
    logic [IW-1:0] gidx;
    logic          xfer;

    // Search downward from the farthest offset so the nearest requester above ptr is the last to win.
    always_comb begin
        int            j;
        logic [IW-1:0] idx;
        gnt  = '0;
        gidx = '0;
        j    = 0;
        idx  = '0;
        if (st == HOLD) begin
            for (int i = 0; i < int'(BN); i++) begin
                if (hgnt[i] && s_vld[i]) begin
                    gnt[i] = 1'b1;
                    gidx   = IW'(i);
                end
            end
        end else begin
            for (int k = int'(BN) - 1; k >= 0; k--) begin
                j = int'(ptr) + k;
                if (j >= int'(BN)) j = j - int'(BN);
                idx = IW'(j);
                if (s_vld[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                    gidx     = idx;
                end
            end
        end
    end

    always_comb begin
        m_wen = 1'b0;
        m_ben = '0;
        m_adr = '0;
        m_wdt = '0;
        for (int i = 0; i < int'(BN); i++) begin
            if (gnt[i]) begin
                m_wen = s_wen[i];
                m_ben = s_ben[i*BW +: BW];
                m_adr = s_adr[i*AW +: AW];
                m_wdt = s_wdt[i*DW +: DW];
            end
        end
    end

    assign m_vld = |(gnt & s_vld);
    assign xfer  = m_vld & m_rdy;
    assign s_rdy = gnt & {BN{m_rdy}};

    for (genvar i = 0; i < int'(BN); i++) begin : g_rdt
        assign s_rdt[i*DW +: DW] = own[i] ? m_rdt : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st   <= ARB;
            ptr  <= '0;
            hgnt <= '0;
            own  <= '0;
        end else begin
            own <= xfer ? gnt : '0;
            if (xfer) ptr <= (gidx == IW'(BN - 1)) ? '0 : gidx + 1'b1;
            case (st)
                ARB: begin
                    if (m_vld && !m_rdy) begin
                        st   <= HOLD;
                        hgnt <= gnt;
                    end
                end
                HOLD: begin
                    // A held manager that withdraws its request is released without a transfer.
                    if (xfer || !(|(hgnt & s_vld))) st <= ARB;
                end
                default: st <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_r5p_bus_arb.sv
// Bench for r5p_bus_arb (BN=3): directed scenarios followed by random traffic,
// all outputs compared each cycle against a round-robin reference model.
module tb_r5p_bus_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int BN = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [BN-1:0]    s_vld;
    logic [BN-1:0]    s_wen;
    logic [BN*BW-1:0] s_ben;
    logic [BN*AW-1:0] s_adr;
    logic [BN*DW-1:0] s_wdt;
    logic [BN*DW-1:0] s_rdt;
    logic [BN-1:0]    s_rdy;
    logic             m_vld;
    logic             m_wen;
    logic [BW-1:0]    m_ben;
    logic [AW-1:0]    m_adr;
    logic [DW-1:0]    m_wdt;
    logic [DW-1:0]    m_rdt;
    logic             m_rdy;

    always #5 clk = ~clk;

    r5p_bus_arb #(.AW(AW), .DW(DW), .BW(BW), .BN(BN)) dut (
        .clk(clk), .rst(rst),
        .s_vld(s_vld), .s_wen(s_wen), .s_ben(s_ben), .s_adr(s_adr), .s_wdt(s_wdt),
        .s_rdt(s_rdt), .s_rdy(s_rdy),
        .m_vld(m_vld), .m_wen(m_wen), .m_ben(m_ben), .m_adr(m_adr), .m_wdt(m_wdt),
        .m_rdt(m_rdt), .m_rdy(m_rdy)
    );

    int total = 0;
    int bad   = 0;

    // reference model: owner/held index as plain integers, -1 meaning none
    int r_ptr  = 0;
    bit r_hold = 0;
    int r_hidx = 0;
    int r_own  = -1;
    int g      = -1;
    int last_x = -1;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_gnt();
        if (r_hold) return s_vld[r_hidx] ? r_hidx : -1;
        for (int k = 0; k < BN; k++)
            if (s_vld[(r_ptr + k) % BN]) return (r_ptr + k) % BN;
        return -1;
    endfunction

    task automatic settle();
        logic [95:0] er;
        logic [2:0]  ey;
        logic        ew;
        logic [3:0]  eb;
        logic [31:0] ea, ed;
        @(negedge clk);
        g  = ref_gnt();
        ew = 1'b0; eb = '0; ea = '0; ed = '0;
        if (g >= 0) begin
            ew = s_wen[g];
            eb = s_ben[g*BW +: BW];
            ea = s_adr[g*AW +: AW];
            ed = s_wdt[g*DW +: DW];
        end
        ey = '0;
        if (g >= 0 && m_rdy) ey[g] = 1'b1;
        er = '0;
        if (r_own >= 0) er[r_own*DW +: DW] = m_rdt;
        chk("m_vld", 96'(m_vld), 96'(g >= 0));
        chk("m_wen", 96'(m_wen), 96'(ew));
        chk("m_ben", 96'(m_ben), 96'(eb));
        chk("m_adr", 96'(m_adr), 96'(ea));
        chk("m_wdt", 96'(m_wdt), 96'(ed));
        chk("s_rdy", 96'(s_rdy), 96'(ey));
        chk("s_rdt", s_rdt, er);
        chk("st",    96'(dut.st),  96'(r_hold));
        chk("ptr",   96'(dut.ptr), 96'(r_ptr));
    endtask

    task automatic tick();
        bit x;
        @(posedge clk);
        x = (g >= 0) && m_rdy;
        last_x = x ? g : -1;
        if (!rst) begin
            r_ptr = 0; r_hold = 0; r_own = -1;
        end else begin
            r_own = x ? g : -1;
            if (x) r_ptr = (g + 1) % BN;
            if (!r_hold) begin
                if (g >= 0 && !m_rdy) begin
                    r_hold = 1; r_hidx = g;
                end
            end else if (x || g < 0) begin
                r_hold = 0;
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic set_req(input int i, input logic wen, input logic [31:0] adr, input logic [31:0] wdt,
                           input logic [3:0] ben);
        s_vld[i] = 1'b1;
        s_wen[i] = wen;
        s_ben[i*BW +: BW] = ben;
        s_adr[i*AW +: AW] = adr;
        s_wdt[i*DW +: DW] = wdt;
    endtask

    logic [2:0] t2_exp [3];

    initial begin
        rst = 1'b0; s_vld = '0; s_wen = '0; s_ben = '0; s_adr = '0; s_wdt = '0;
        m_rdt = 32'h1234_5678; m_rdy = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // reset state visible on outputs
        settle();
        chk("rst_rdt", s_rdt, '0);
        tick();

        // single read from manager 0, zero added latency, data next cycle
        rst = 1'b1;
        set_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
        m_rdy = 1'b1;
        settle();
        chk("t1_adr", 96'(m_adr), 96'h100);
        chk("t1_rdy", 96'(s_rdy), 96'b001);
        tick();
        s_vld[0] = 1'b0;
        m_rdt = 32'hDEAD_BEEF;
        settle();
        chk("t1_rdt0", 96'(s_rdt[31:0]), 96'hDEAD_BEEF);
        chk("t1_rdt1", 96'(s_rdt[63:32]), 96'h0);
        tick();

        // two continuous requesters alternate; ptr starts at 1
        t2_exp = '{3'b010, 3'b001, 3'b010};
        set_req(0, 1'b1, 32'h10, 32'hA0, 4'h3);
        set_req(1, 1'b0, 32'h20, 32'hB0, 4'hC);
        for (int j = 0; j < 3; j++) begin
            settle();
            chk("t2_rdy", 96'(s_rdy), 96'(t2_exp[j]));
            tick();
            if (last_x >= 0) set_req(last_x, 1'b1, 32'h40 + 32'(j), 32'hC0 + 32'(j), 4'h5);
        end

        // stall with manager 1 held while manager 0 (higher priority from ptr=2) waits
        s_vld[0] = 1'b0;
        set_req(1, 1'b0, 32'h200, 32'h0, 4'hF);
        m_rdy = 1'b0;
        settle();
        chk("t3_ptr", 96'(dut.ptr), 96'd2);
        chk("t3_rdy", 96'(s_rdy), 96'b000);
        tick();
        set_req(0, 1'b0, 32'h300, 32'h0, 4'hF);
        for (int j = 0; j < 2; j++) begin
            settle();
            chk("t3_hold", 96'(dut.st), 96'd1);
            chk("t3_adr", 96'(m_adr), 96'h200);
            tick();
        end
        m_rdy = 1'b1;
        settle();
        chk("t3_xfer", 96'(s_rdy), 96'b010);
        tick();
        s_vld[1] = 1'b0;
        settle();
        chk("t3_next", 96'(s_rdy), 96'b001);
        tick();
        s_vld = '0;

        // wrap of ptr from BN-1 back to 0
        rst = 1'b0;
        step();
        rst = 1'b1;
        set_req(2, 1'b1, 32'h400, 32'h44, 4'hF);
        settle();
        chk("t4_rdy2", 96'(s_rdy), 96'b100);
        tick();
        set_req(0, 1'b0, 32'h500, 32'h0, 4'hF);
        set_req(2, 1'b0, 32'h600, 32'h0, 4'hF);
        settle();
        chk("t4_ptr", 96'(dut.ptr), 96'd0);
        chk("t4_rdy0", 96'(s_rdy), 96'b001);
        tick();
        s_vld = '0;

        // reset during a completing read drops its data
        set_req(0, 1'b0, 32'h700, 32'h0, 4'hF);
        m_rdy = 1'b1;
        rst = 1'b0;
        step();
        rst = 1'b1;
        s_vld = '0;
        m_rdt = 32'hCAFE_F00D;
        settle();
        chk("t5_rdt", s_rdt, '0);
        chk("t5_ptr", 96'(dut.ptr), 96'd0);
        chk("t5_st", 96'(dut.st), 96'd0);
        tick();

        // held manager withdraws: no transfer, back to ARB, ptr unchanged
        set_req(0, 1'b0, 32'h800, 32'h0, 4'hF);
        step();
        s_vld[0] = 1'b0;
        set_req(2, 1'b0, 32'h900, 32'h0, 4'hF);
        m_rdy = 1'b0;
        step();
        s_vld[2] = 1'b0;
        settle();
        chk("t6_vld", 96'(m_vld), 96'd0);
        chk("t6_hold", 96'(dut.st), 96'd1);
        tick();
        settle();
        chk("t6_st", 96'(dut.st), 96'd0);
        chk("t6_ptr", 96'(dut.ptr), 96'd1);
        tick();

        // random traffic obeying the hold-until-ready protocol
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < BN; i++) begin
                if (!s_vld[i] || last_x == i) begin
                    if ($urandom_range(1, 0) != 0)
                        set_req(i, 1'($urandom_range(1, 0)), $urandom, $urandom, 4'($urandom_range(15, 1)));
                    else
                        s_vld[i] = 1'b0;
                end
            end
            m_rdy = ($urandom_range(3, 0) != 0);
            m_rdt = $urandom;
            rst   = ($urandom_range(63, 0) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
